// File: rtl/vectored_intc_if.sv
// Signal bundle between the vectored interrupt controller and its
// peripherals/core: done lines, mask access, request/ack and end-of-interrupt.
interface vectored_intc_if #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 32
) ();
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] src_done;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wd;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               int_req;
  logic [IDX_W-1:0]   int_id;
  logic [ADDR_W-1:0]  int_addr;
  logic               int_ack;
  logic               eoi;
  logic               status_bit;

  // Controller side
  modport slave (
    input  src_done, mask_we, mask_wd, int_ack, eoi,
    output mask, pending, int_req, int_id, int_addr, status_bit
  );

  // Peripheral/core side
  modport master (
    output src_done, mask_we, mask_wd, int_ack, eoi,
    input  mask, pending, int_req, int_id, int_addr, status_bit
  );
endinterface

// File: rtl/vectored_intc.sv
// Vectored interrupt controller: edge-latched pending bits, software mask,
// fixed priority (index 0 highest) and a single in-service slot until EOI.
module vectored_intc #(
  parameter int                NUM_SRC    = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                   clk,
  input  logic                   reset,
  vectored_intc_if.slave         bus
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [IDX_W-1:0]   r_int_id;
  logic [ADDR_W-1:0]  r_int_addr;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_clr;
  logic [IDX_W-1:0]   w_win_idx;
  logic [ADDR_W-1:0]  w_win_addr;
  logic               w_ack_ok;

  assign w_rise   = bus.src_done & ~r_src_prev;
  assign w_active = r_pending & r_mask;
  assign w_ack_ok = (r_state == S_REQ) && bus.int_ack;
  assign w_clr    = w_ack_ok ? (NUM_SRC'(1) << r_int_id) : '0;

  // Descending scan so the lowest active index is the last one written.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_win_idx unassigned (no latch).
    w_win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_win_idx = IDX_W'(i);
    end
  end

  assign w_win_addr = VEC_BASE + ADDR_W'(w_win_idx) * VEC_STRIDE;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    r_src_prev <= bus.src_done;
    if (reset) begin
      // Sampling src_done during reset means a line held high gives no edge.
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_mask     <= '1;
      r_int_id   <= '0;
      r_int_addr <= VEC_BASE;
    end else begin
      // Set wins over clear when a new edge lands on the acked source.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (bus.mask_we) r_mask <= bus.mask_wd;

      case (r_state)
        S_IDLE: begin
          if (|w_active) begin
            r_int_id   <= w_win_idx;
            r_int_addr <= w_win_addr;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack_ok) r_state <= S_SERVICE;
        end
        S_SERVICE: begin
          if (bus.eoi) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mask       = r_mask;
  assign bus.pending    = r_pending;
  assign bus.int_req    = (r_state == S_REQ);
  assign bus.status_bit = (r_state == S_SERVICE);
  assign bus.int_id     = r_int_id;
  assign bus.int_addr   = r_int_addr;
endmodule

// File: tb/tb_vectored_intc.sv
// Directed bench for vectored_intc: a default 4-source build and an
// 8-source build with a 0x20 vector stride.
module tb_vectored_intc;
  logic clk = 1'b0;
  logic reset;
  logic reset8;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vectored_intc_if #(.NUM_SRC(4), .ADDR_W(32)) bus4 ();
  vectored_intc_if #(.NUM_SRC(8), .ADDR_W(32)) bus8 ();

  vectored_intc #(
    .NUM_SRC(4), .ADDR_W(32), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  vectored_intc #(
    .NUM_SRC(8), .ADDR_W(32), .VEC_BASE(32'h100), .VEC_STRIDE(32'h20)
  ) u_dut8 (
    .clk(clk), .reset(reset8), .bus(bus8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    reset8 = 1'b1;
    bus4.src_done = 4'b0010; bus4.mask_we = 1'b0; bus4.mask_wd = 4'h0;
    bus4.int_ack = 1'b0; bus4.eoi = 1'b0;
    bus8.src_done = 8'h00; bus8.mask_we = 1'b0; bus8.mask_wd = 8'h00;
    bus8.int_ack = 1'b0; bus8.eoi = 1'b0;

    // Reset held two cycles with src 1 high
    tick(); tick();
    check("rst_pending", 32'(bus4.pending), 32'h0);
    check("rst_mask", 32'(bus4.mask), 32'hF);
    check("rst_req", 32'(bus4.int_req), 32'h0);
    check("rst_id", 32'(bus4.int_id), 32'h0);
    check("rst_addr", bus4.int_addr, 32'h100);
    check("rst_status", 32'(bus4.status_bit), 32'h0);
    reset = 1'b0;
    reset8 = 1'b0;
    tick(); tick(); tick();
    check("rel_no_pending", 32'(bus4.pending), 32'h0);
    check("rel_no_req", 32'(bus4.int_req), 32'h0);
    bus4.src_done = 4'b0000;
    tick();

    // Single source 2
    bus4.src_done = 4'b0100;
    tick();
    check("single_pending", 32'(bus4.pending), 32'h4);
    check("single_req_e0", 32'(bus4.int_req), 32'h0);
    tick();
    check("single_req", 32'(bus4.int_req), 32'h1);
    check("single_id", 32'(bus4.int_id), 32'h2);
    check("single_addr", bus4.int_addr, 32'h120);
    bus4.src_done = 4'b0000;
    bus4.int_ack = 1'b1;
    tick();
    bus4.int_ack = 1'b0;
    check("single_ack_req", 32'(bus4.int_req), 32'h0);
    check("single_ack_status", 32'(bus4.status_bit), 32'h1);
    check("single_ack_pending", 32'(bus4.pending), 32'h0);
    tick();
    check("single_hold_status", 32'(bus4.status_bit), 32'h1);
    bus4.eoi = 1'b1;
    tick();
    bus4.eoi = 1'b0;
    check("single_eoi_status", 32'(bus4.status_bit), 32'h0);
    check("single_eoi_req", 32'(bus4.int_req), 32'h0);
    tick();

    // Priority: sources 1 and 3 together
    bus4.src_done = 4'b1010;
    tick();
    bus4.src_done = 4'b0000;
    check("prio_pending", 32'(bus4.pending), 32'hA);
    tick();
    check("prio_req1", 32'(bus4.int_req), 32'h1);
    check("prio_id1", 32'(bus4.int_id), 32'h1);
    check("prio_addr1", bus4.int_addr, 32'h110);
    bus4.int_ack = 1'b1;
    tick();
    bus4.int_ack = 1'b0;
    check("prio_pending_after_ack", 32'(bus4.pending), 32'h8);
    tick(); tick(); tick();
    check("prio_no_req_in_service", 32'(bus4.int_req), 32'h0);
    check("prio_status_held", 32'(bus4.status_bit), 32'h1);
    bus4.eoi = 1'b1;
    tick();
    bus4.eoi = 1'b0;
    check("prio_idle_gap_req", 32'(bus4.int_req), 32'h0);
    tick();
    check("prio_req3", 32'(bus4.int_req), 32'h1);
    check("prio_id3", 32'(bus4.int_id), 32'h3);
    check("prio_addr3", bus4.int_addr, 32'h130);
    bus4.int_ack = 1'b1;
    tick();
    bus4.int_ack = 1'b0;
    bus4.eoi = 1'b1;
    tick();
    bus4.eoi = 1'b0;

    // Masking
    bus4.mask_we = 1'b1; bus4.mask_wd = 4'b1101;
    tick();
    bus4.mask_we = 1'b0;
    check("mask_written", 32'(bus4.mask), 32'hD);
    bus4.src_done = 4'b0010;
    tick();
    bus4.src_done = 4'b0000;
    check("mask_pending_set", 32'(bus4.pending), 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mask_blocks_req", 32'(bus4.int_req), 32'h0);
    end
    bus4.mask_we = 1'b1; bus4.mask_wd = 4'b1111;
    tick();
    bus4.mask_we = 1'b0;
    check("unmask_old_mask_edge", 32'(bus4.int_req), 32'h0);
    tick();
    check("unmask_req", 32'(bus4.int_req), 32'h1);
    check("unmask_id", 32'(bus4.int_id), 32'h1);
    bus4.mask_we = 1'b1; bus4.mask_wd = 4'b1101;
    tick();
    bus4.mask_we = 1'b0;
    tick();
    check("mask_in_req_keeps_req", 32'(bus4.int_req), 32'h1);
    check("mask_in_req_keeps_id", 32'(bus4.int_id), 32'h1);
    bus4.int_ack = 1'b1;
    tick();
    bus4.int_ack = 1'b0;
    bus4.mask_we = 1'b1; bus4.mask_wd = 4'b1111;
    bus4.eoi = 1'b1;
    tick();
    bus4.mask_we = 1'b0;
    bus4.eoi = 1'b0;

    // Set and clear of pending[0] on the same edge
    bus4.src_done = 4'b0001;
    tick();
    bus4.src_done = 4'b0000;
    tick();
    check("simul_req0", 32'(bus4.int_id), 32'h0);
    bus4.src_done = 4'b0001;
    bus4.int_ack = 1'b1;
    tick();
    bus4.int_ack = 1'b0;
    bus4.src_done = 4'b0000;
    check("simul_pending_kept", 32'(bus4.pending), 32'h1);
    check("simul_status", 32'(bus4.status_bit), 32'h1);
    bus4.eoi = 1'b1;
    tick();
    bus4.eoi = 1'b0;
    tick();
    check("simul_rereq", 32'(bus4.int_req), 32'h1);
    check("simul_rereq_id", 32'(bus4.int_id), 32'h0);
    check("simul_rereq_addr", bus4.int_addr, 32'h100);

    // 8-source build, stride 0x20
    bus8.src_done = 8'h80;
    tick();
    bus8.src_done = 8'h00;
    check("p8_pending", 32'(bus8.pending), 32'h80);
    tick();
    check("p8_req", 32'(bus8.int_req), 32'h1);
    check("p8_id", 32'(bus8.int_id), 32'h7);
    check("p8_addr", bus8.int_addr, 32'h1E0);
    bus8.int_ack = 1'b1;
    tick();
    bus8.int_ack = 1'b0;
    check("p8_status", 32'(bus8.status_bit), 32'h1);
    bus8.src_done = 8'h01;
    tick();
    check("p8_accumulate", 32'(bus8.pending), 32'h01);
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    check("p8_rst_status", 32'(bus8.status_bit), 32'h0);
    check("p8_rst_pending", 32'(bus8.pending), 32'h0);
    check("p8_rst_req", 32'(bus8.int_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
